phase_controller: RTL and testbench

PHASE_CONTROLLER -- requirements
Module: phase_controller

---
 rtl/phase_controller_pkg.sv | 50 +++++
 rtl/instr_classifier.sv | 33 +++
 rtl/phase_controller.sv | 112 +++++++++++
 tb/tb_phase_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_controller_pkg.sv
// Shared definitions for the five-phase instruction sequencer: state encoding,
// instruction field codes and the classifier result bundle.
package phase_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_P2   = 3'd2,
        ST_P3   = 3'd3,
        ST_P4   = 3'd4,
        ST_P5   = 3'd5,
        ST_HALT = 3'd6
    } state_e;

    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_BR  = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    localparam logic [2:0] OP2_LI  = 3'b000;

    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_RSV = 4'b1110;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    typedef struct packed {
        logic is_ld;
        logic is_st;
        logic is_out;
        logic is_hlt;
        logic writes_rf;
    } instr_class_t;

    // One-hot phase indicator, bit0 = P1; zero outside the busy states.
    function automatic logic [4:0] phase_onehot(input state_e s);
        logic [4:0] p;
        p = 5'b00000;
        case (s)
            ST_P1:   p = 5'b00001;
            ST_P2:   p = 5'b00010;
            ST_P3:   p = 5'b00100;
            ST_P4:   p = 5'b01000;
            ST_P5:   p = 5'b10000;
            default: p = 5'b00000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/instr_classifier.sv
// Purely combinational decode of the instruction fields into the handful of
// properties the sequencer needs.
module instr_classifier
    import phase_controller_pkg::*;
(
    input  logic [1:0] op1,
    input  logic [2:0] op2,
    input  logic [3:0] op3,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_out,
    output logic       is_hlt,
    output logic       writes_rf
);

    logic is_alu;
    logic alu_no_wb;

    assign is_alu = (op1 == OP1_ALU);
    assign is_ld  = (op1 == OP1_LD);
    assign is_st  = (op1 == OP1_ST);
    assign is_out = is_alu && (op3 == OP3_OUT);
    assign is_hlt = is_alu && (op3 == OP3_HLT);

    // Compare only sets flags, OUT/HLT have no result, the reserved code is a no-op.
    assign alu_no_wb = (op3 == OP3_CMP) || (op3 == OP3_OUT) ||
                       (op3 == OP3_RSV) || (op3 == OP3_HLT);

    assign writes_rf = is_ld ||
                       (is_alu && !alu_no_wb) ||
                       ((op1 == OP1_BR) && (op2 == OP2_LI));

endmodule

// File: rtl/phase_controller.sv
// Five-phase instruction sequencer (fetch, decode, execute, memory/IO, writeback)
// with IDLE/HALT states, memory and output-device handshakes, and single-step.
module phase_controller
    import phase_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step,
    input  logic [1:0] op1,
    input  logic [2:0] op2,
    input  logic [3:0] op3,
    input  logic       mem_ack,
    input  logic       out_ready,
    output logic [4:0] phase,
    output logic       ir_we,
    output logic       pc_we,
    output logic       rf_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       out_valid,
    output logic       busy,
    output logic       halted
);

    state_e       state_q;
    instr_class_t cls;
    logic         p4_mem;

    instr_classifier u_classifier (
        .op1       (op1),
        .op2       (op2),
        .op3       (op3),
        .is_ld     (cls.is_ld),
        .is_st     (cls.is_st),
        .is_out    (cls.is_out),
        .is_hlt    (cls.is_hlt),
        .writes_rf (cls.writes_rf)
    );

    assign p4_mem = cls.is_ld || cls.is_st;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_q <= ST_P1;
                ST_P1:   if (mem_ack) state_q <= ST_P2;
                ST_P2:   state_q <= ST_P3;
                ST_P3:   state_q <= cls.is_hlt ? ST_HALT : ST_P4;
                ST_P4: begin
                    // Only the handshake that belongs to this instruction can release P4.
                    if (p4_mem) begin
                        if (mem_ack) state_q <= ST_P5;
                    end else if (cls.is_out) begin
                        if (out_ready) state_q <= ST_P5;
                    end else begin
                        state_q <= ST_P5;
                    end
                end
                ST_P5:   state_q <= step ? ST_IDLE : ST_P1;
                ST_HALT: if (start) state_q <= ST_P1;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state and op fields; reset forces them all low.
    always_comb begin
        phase     = 5'b00000;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        if (!rst) begin
            phase = phase_onehot(state_q);
            case (state_q)
                ST_P1: begin
                    busy    = 1'b1;
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                end
                ST_P2, ST_P3: begin
                    busy = 1'b1;
                end
                ST_P4: begin
                    busy      = 1'b1;
                    mem_req   = p4_mem;
                    mem_we    = cls.is_st;
                    out_valid = cls.is_out;
                end
                ST_P5: begin
                    busy  = 1'b1;
                    pc_we = 1'b1;
                    rf_we = cls.writes_rf;
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_controller.sv
// Bench for phase_controller: per-instruction expected output traces built from
// the sequencing rules, compared every cycle, plus literal checks on directed runs.
module tb_phase_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       step;
  logic [1:0] op1;
  logic [2:0] op2;
  logic [3:0] op3;
  logic       mem_ack;
  logic       out_ready;
  logic [4:0] phase;
  logic       ir_we, pc_we, rf_we, mem_req, mem_we, out_valid, busy, halted;

  logic [1:0] op1_n;
  logic [2:0] op2_n;
  logic [3:0] op3_n;

  // Word layout: {phase[4:0], ir_we, pc_we, rf_we, mem_req, mem_we, out_valid, busy, halted}
  logic [12:0] exp_q[$];
  logic [12:0] mon_q[$];
  int          n_vec;
  int          n_err;
  int          mode;

  phase_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .step      (step),
    .op1       (op1),
    .op2       (op2),
    .op3       (op3),
    .mem_ack   (mem_ack),
    .out_ready (out_ready),
    .phase     (phase),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .rf_we     (rf_we),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .out_valid (out_valid),
    .busy      (busy),
    .halted    (halted)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model helpers ----------------
  // ph: 0 = idle, 1..5 = P1..P5, 6 = halt
  function automatic logic [12:0] expw(input int ph, input logic irw, input logic pcw,
                                       input logic rfw, input logic mrq, input logic mwe,
                                       input logic ov);
    logic [4:0] p;
    logic       bsy;
    logic       hlt;
    p = 5'd0;
    bsy = 1'b0;
    hlt = (ph == 6);
    if (ph >= 1 && ph <= 5) begin
      p = 5'd1 << (ph - 1);
      bsy = 1'b1;
    end
    return {p, irw, pcw, rfw, mrq, mwe, ov, bsy, hlt};
  endfunction

  function automatic logic model_writes(input logic [1:0] o1, input logic [2:0] o2,
                                        input logic [3:0] o3);
    case (o1)
      2'd0:    return 1'b1;
      2'd1:    return 1'b0;
      2'd2:    return (o2 == 3'd0);
      default: return !(o3 == 4'd5 || o3 == 4'd13 || o3 == 4'd14 || o3 == 4'd15);
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int cnt(input logic [12:0] mask, input logic [12:0] val);
    int n;
    n = 0;
    foreach (mon_q[i]) if ((mon_q[i] & mask) == val) n++;
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic s, input logic stp, input logic ack,
                       input logic rdy, input logic [12:0] e);
    @(posedge clk);
    #1;
    rst = r;
    start = s;
    step = stp;
    mem_ack = ack;
    out_ready = rdy;
    op1 = op1_n;
    op2 = op2_n;
    op3 = op3_n;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    n_vec++;
    if (got != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
    end
  endtask

  task automatic clr_log();
    @(negedge clk);
    #1;
    mon_q.delete();
  endtask

  task automatic flush();
    @(negedge clk);
    #1;
  endtask

  // From IDLE or HALT: a few quiet cycles, then the start pulse.
  task automatic do_start(input int md, input int quiet);
    int ph;
    ph = (md == 2) ? 6 : 0;
    for (int i = 0; i < quiet; i++) drive(0, 0, rb(), rb(), rb(), expw(ph, 0, 0, 0, 0, 0, 0));
    drive(0, 1, rb(), rb(), rb(), expw(ph, 0, 0, 0, 0, 0, 0));
  endtask

  // One instruction from P1. abort: 1 = reset during P1 stall, 2 = reset during P4 memory stall.
  task automatic run_instr(input logic [1:0] o1, input logic [2:0] o2, input logic [3:0] o3,
                           input int w1, input int w4, input logic stp, input int abort,
                           output int md);
    logic hlt, isout, ismem, st, wr;
    op1_n = o1;
    op2_n = o2;
    op3_n = o3;
    hlt   = (o1 == 2'd3) && (o3 == 4'd15);
    isout = (o1 == 2'd3) && (o3 == 4'd13);
    ismem = (o1 < 2'd2);
    st    = (o1 == 2'd1);
    wr    = model_writes(o1, o2, o3);
    for (int i = 0; i < w1; i++) drive(0, rb(), rb(), 0, rb(), expw(1, 0, 0, 0, 1, 0, 0));
    if (abort == 1) begin
      drive(1, 1, rb(), 1, 1, expw(0, 0, 0, 0, 0, 0, 0));
      md = 0;
      return;
    end
    drive(0, rb(), rb(), 1, rb(), expw(1, 1, 0, 0, 1, 0, 0));
    drive(0, rb(), rb(), rb(), rb(), expw(2, 0, 0, 0, 0, 0, 0));
    drive(0, rb(), rb(), rb(), rb(), expw(3, 0, 0, 0, 0, 0, 0));
    if (hlt) begin
      md = 2;
      return;
    end
    if (ismem) begin
      for (int i = 0; i < w4; i++) drive(0, rb(), rb(), 0, rb(), expw(4, 0, 0, 0, 1, st, 0));
      if (abort == 2) begin
        drive(1, 1, rb(), 1, 1, expw(0, 0, 0, 0, 0, 0, 0));
        md = 0;
        return;
      end
      drive(0, rb(), rb(), 1, rb(), expw(4, 0, 0, 0, 1, st, 0));
    end else if (isout) begin
      for (int i = 0; i < w4; i++) drive(0, rb(), rb(), rb(), 0, expw(4, 0, 0, 0, 0, 0, 1));
      drive(0, rb(), rb(), rb(), 1, expw(4, 0, 0, 0, 0, 0, 1));
    end else begin
      drive(0, rb(), rb(), rb(), rb(), expw(4, 0, 0, 0, 0, 0, 0));
    end
    drive(0, rb(), stp, rb(), rb(), expw(5, 0, 1, wr, 0, 0, 0));
    md = stp ? 0 : 1;
  endtask

  // ---------------- scoreboard ----------------
  initial begin
    logic [12:0] e;
    logic [12:0] got;
    forever begin
      @(negedge clk);
      got = {phase, ir_we, pc_we, rf_we, mem_req, mem_we, out_valid, busy, halted};
      mon_q.push_back(got);
      if (mon_q.size() > 64) void'(mon_q.pop_front());
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
          n_err++;
          $display("FAIL cycle_trace @%0t: got %b, expected %b (phase|ir pc rf mreq mwe ov busy halt)",
                   $time, got, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] o1;
    logic [2:0] o2;
    logic [3:0] o3;
    int         w1, w4, ab, rfv, pcv;
    logic       stp;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    step = 1'b0;
    mem_ack = 1'b0;
    out_ready = 1'b0;
    op1_n = 2'd0;
    op2_n = 3'd0;
    op3_n = 4'd0;
    op1 = 2'd0;
    op2 = 3'd0;
    op3 = 4'd0;

    // reset, with start and handshakes high to show they are overridden
    drive(1, 1, 0, 1, 1, expw(0, 0, 0, 0, 0, 0, 0));
    drive(1, 1, 0, 1, 1, expw(0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 1, 1, expw(0, 0, 0, 0, 0, 0, 0));
    flush();
    chk("reset_outputs", int'(mon_q[mon_q.size() - 1]), 0);

    // ADD twice with handshakes effectively tied high: 5 cycles each, back to P1
    do_start(0, 0);
    clr_log();
    run_instr(2'd3, 3'd0, 4'd0, 0, 0, 0, 0, mode);
    run_instr(2'd3, 3'd0, 4'd0, 0, 0, 1, 0, mode);
    flush();
    chk("add_phase_p1", int'(mon_q[0][12:8]), 1);
    chk("add_phase_p2", int'(mon_q[1][12:8]), 2);
    chk("add_phase_p3", int'(mon_q[2][12:8]), 4);
    chk("add_phase_p4", int'(mon_q[3][12:8]), 8);
    chk("add_phase_p5", int'(mon_q[4][12:8]), 16);
    chk("add_return_p1", int'(mon_q[5][12:8]), 1);
    rfv = 0;
    pcv = 0;
    for (int i = 0; i < 5; i++) begin
      rfv |= int'(mon_q[i][5]) << i;
      pcv |= int'(mon_q[i][6]) << i;
    end
    chk("add_rf_we_p5_only", rfv, 16);
    chk("add_pc_we_p5_only", pcv, 16);

    // LD with a 3-cycle memory delay in P4
    do_start(0, 1);
    clr_log();
    run_instr(2'd0, 3'd5, 4'd9, 0, 3, 1, 0, mode);
    flush();
    chk("ld_total_cycles", cnt(13'h0002, 13'h0002), 8);
    chk("ld_p4_read_cycles", cnt({5'h1f, 8'h18}, {5'h08, 8'h10}), 4);
    chk("ld_rf_we", cnt(13'h0020, 13'h0020), 1);

    // ST with a 1-cycle memory delay
    do_start(0, 0);
    clr_log();
    run_instr(2'd1, 3'd0, 4'd0, 1, 1, 1, 0, mode);
    flush();
    chk("st_p4_write_cycles", cnt({5'h1f, 8'h18}, {5'h08, 8'h18}), 2);
    chk("st_rf_we", cnt(13'h0020, 13'h0020), 0);

    // OUT with out_ready low for 2 cycles
    do_start(0, 0);
    clr_log();
    run_instr(2'd3, 3'd0, 4'd13, 0, 2, 1, 0, mode);
    flush();
    chk("out_valid_cycles", cnt(13'h0004, 13'h0004), 3);
    chk("out_rf_we", cnt(13'h0020, 13'h0020), 0);

    // HLT, then resume with start
    do_start(0, 0);
    clr_log();
    run_instr(2'd3, 3'd0, 4'd15, 0, 0, 0, 0, mode);
    drive(0, 0, 0, 1, 1, expw(6, 0, 0, 0, 0, 0, 0));
    flush();
    chk("hlt_halted", int'(mon_q[mon_q.size() - 1][0]), 1);
    chk("hlt_no_pc_we", cnt(13'h0040, 13'h0040), 0);
    do_start(2, 1);
    clr_log();
    run_instr(2'd2, 3'd0, 4'd0, 0, 0, 1, 0, mode);
    flush();
    chk("resume_p1", int'(mon_q[0][12:8]), 1);
    chk("li_rf_we", cnt(13'h0020, 13'h0020), 1);

    // reset during a P1 stall with mem_ack high in the same cycle
    do_start(0, 0);
    run_instr(2'd3, 3'd0, 4'd0, 2, 0, 0, 1, mode);
    drive(0, 0, 0, 1, 1, expw(0, 0, 0, 0, 0, 0, 0));
    flush();
    chk("rst_p1_outputs", int'(mon_q[mon_q.size() - 1]), 0);

    // reset during a P4 memory stall
    do_start(0, 0);
    run_instr(2'd0, 3'd0, 4'd0, 0, 2, 0, 2, mode);
    drive(0, 0, 0, 1, 1, expw(0, 0, 0, 0, 0, 0, 0));
    flush();
    chk("rst_p4_mem_req", int'(mon_q[mon_q.size() - 1][4]), 0);

    // randomized instruction stream
    mode = 0;
    for (int n = 0; n < 250; n++) begin
      if (mode != 1) do_start(mode, $urandom_range(0, 2));
      o1 = 2'($urandom_range(0, 3));
      o2 = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       o3 = 4'd5;
        1:       o3 = 4'd13;
        2:       o3 = 4'd14;
        3:       o3 = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'd0;
        default: o3 = 4'($urandom_range(0, 15));
      endcase
      w1 = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      w4 = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      stp = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 2) : 0;
      run_instr(o1, o2, o3, w1, w4, stp, ab, mode);
    end
    drive(0, 0, 0, 0, 0, expw(mode == 2 ? 6 : (mode == 1 ? 1 : 0), 0, 0, 0,
                              mode == 1, 0, 0));
    flush();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
